// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding, load-use/branch stalls and multi-cycle EX occupancy control.
// Optional macro HAZARD_BRANCH_FWD_EN enables decode-stage branch operand forwarding.
module hazard_ctrl #(
  parameter int unsigned REG_BITS = 4,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_BITS-1:0] rs_d,
  input  logic [REG_BITS-1:0] rt_d,
  input  logic                uses_rs_d,
  input  logic                uses_rt_d,
  input  logic                branch_d,
  input  logic                branch_taken_d,
  input  logic [REG_BITS-1:0] rs_e,
  input  logic [REG_BITS-1:0] rt_e,
  input  logic [REG_BITS-1:0] dst_e,
  input  logic                reg_wren_e,
  input  logic                mem_to_reg_e,
  input  logic                multi_e,
  input  logic [REG_BITS-1:0] dst_m,
  input  logic [REG_BITS-1:0] dst_w,
  input  logic                reg_wren_m,
  input  logic                mem_to_reg_m,
  input  logic                reg_wren_w,
  output logic                stall_f,
  output logic                stall_d,
  output logic                stall_e,
  output logic                flush_d,
  output logic                flush_e,
  output logic                flush_m,
  output logic [1:0]          fwd_a_e,
  output logic [1:0]          fwd_b_e,
  output logic [1:0]          fwd_a_d,
  output logic [1:0]          fwd_b_d,
  output logic                busy,
  output logic [CNT_BITS-1:0] stall_cnt
);

  localparam int unsigned MCNT_BITS = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [MCNT_BITS-1:0] MCNT_INIT = MCNT_BITS'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam bit CAN_BUSY = (MUL_LAT > 1);

  typedef enum logic {RUN, MBUSY} stateT;

  stateT                state;
  logic [MCNT_BITS-1:0] mcnt;
  logic                 mdone;

  function automatic logic writes(input logic wren, input logic [REG_BITS-1:0] dst,
                                  input logic [REG_BITS-1:0] r);
    return wren && (dst == r) && (r != '0);
  endfunction

  // MEM result is younger than WB, so it wins
  function automatic logic [1:0] fwdSel(input logic mHit, input logic wHit);
    return mHit ? 2'b01 : (wHit ? 2'b10 : 2'b00);
  endfunction

  logic eHitRs, eHitRt, mHitRs, mHitRt, wHitRs, wHitRt;
  logic baseDepRs, baseDepRt, depRs, depRt;
  logic loadUse, branchDep;

  assign fwd_a_e = fwdSel(writes(reg_wren_m, dst_m, rs_e), writes(reg_wren_w, dst_w, rs_e));
  assign fwd_b_e = fwdSel(writes(reg_wren_m, dst_m, rt_e), writes(reg_wren_w, dst_w, rt_e));

  assign eHitRs = writes(reg_wren_e, dst_e, rs_d);
  assign eHitRt = writes(reg_wren_e, dst_e, rt_d);
  assign mHitRs = writes(reg_wren_m, dst_m, rs_d);
  assign mHitRt = writes(reg_wren_m, dst_m, rt_d);
  assign wHitRs = writes(reg_wren_w, dst_w, rs_d);
  assign wHitRt = writes(reg_wren_w, dst_w, rt_d);

  assign baseDepRs = eHitRs | (mem_to_reg_m & mHitRs);
  assign baseDepRt = eHitRt | (mem_to_reg_m & mHitRt);

`ifdef HAZARD_BRANCH_FWD_EN
  assign depRs   = baseDepRs;
  assign depRt   = baseDepRt;
  assign fwd_a_d = branch_d ? fwdSel(mHitRs, wHitRs) : 2'b00;
  assign fwd_b_d = branch_d ? fwdSel(mHitRt, wHitRt) : 2'b00;
`else
  // without decode forwarding the branch waits until the value reaches the register file
  assign depRs   = baseDepRs | mHitRs | wHitRs;
  assign depRt   = baseDepRt | mHitRt | wHitRt;
  assign fwd_a_d = 2'b00;
  assign fwd_b_d = 2'b00;
`endif

  assign loadUse   = mem_to_reg_e & ((uses_rs_d & eHitRs) | (uses_rt_d & eHitRt));
  assign branchDep = branch_d & ((uses_rs_d & depRs) | (uses_rt_d & depRt));

  // mdone masks re-entry on the cycle the finished op is still in EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      mcnt  <= '0;
      mdone <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          mdone <= 1'b0;
          if (CAN_BUSY && multi_e && !mdone) begin
            state <= MBUSY;
            mcnt  <= MCNT_INIT;
          end
        end
        MBUSY: begin
          if (mcnt == '0) begin
            state <= RUN;
            mdone <= 1'b1;
          end else begin
            mcnt <= mcnt - MCNT_BITS'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (rst_n) begin
      if (state == MBUSY) begin
        busy    = 1'b1;
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (loadUse || branchDep) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        flush_d = branch_taken_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_d && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_ctrl;

  localparam int LAT0 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] rs_d, rt_d, rs_e, rt_e, dst_e, dst_m, dst_w;
  logic       uses_rs_d, uses_rt_d, branch_d, branch_taken_d;
  logic       reg_wren_e, mem_to_reg_e, multi_e, reg_wren_m, mem_to_reg_m, reg_wren_w;

  logic       stallF[2], stallD[2], stallE[2], flushD[2], flushE[2], flushM[2], busyO[2];
  logic [1:0] fwdAE[2], fwdBE[2], fwdAD[2], fwdBD[2];
  logic [15:0] stallCnt0;
  logic [1:0]  stallCnt1;

  int errors = 0;
  int checks = 0;

  // model state: remaining busy cycles, re-entry mask, stall counters
  int left0 = 0;
  bit done0 = 0;
  int cnt0  = 0;
  int cnt1  = 0;

  hazard_ctrl #(.REG_BITS(4), .MUL_LAT(LAT0), .CNT_BITS(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
    .branch_d(branch_d), .branch_taken_d(branch_taken_d), .rs_e(rs_e), .rt_e(rt_e), .dst_e(dst_e),
    .reg_wren_e(reg_wren_e), .mem_to_reg_e(mem_to_reg_e), .multi_e(multi_e), .dst_m(dst_m), .dst_w(dst_w),
    .reg_wren_m(reg_wren_m), .mem_to_reg_m(mem_to_reg_m), .reg_wren_w(reg_wren_w),
    .stall_f(stallF[0]), .stall_d(stallD[0]), .stall_e(stallE[0]), .flush_d(flushD[0]),
    .flush_e(flushE[0]), .flush_m(flushM[0]), .fwd_a_e(fwdAE[0]), .fwd_b_e(fwdBE[0]),
    .fwd_a_d(fwdAD[0]), .fwd_b_d(fwdBD[0]), .busy(busyO[0]), .stall_cnt(stallCnt0));

  hazard_ctrl #(.REG_BITS(4), .MUL_LAT(1), .CNT_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
    .branch_d(branch_d), .branch_taken_d(branch_taken_d), .rs_e(rs_e), .rt_e(rt_e), .dst_e(dst_e),
    .reg_wren_e(reg_wren_e), .mem_to_reg_e(mem_to_reg_e), .multi_e(multi_e), .dst_m(dst_m), .dst_w(dst_w),
    .reg_wren_m(reg_wren_m), .mem_to_reg_m(mem_to_reg_m), .reg_wren_w(reg_wren_w),
    .stall_f(stallF[1]), .stall_d(stallD[1]), .stall_e(stallE[1]), .flush_d(flushD[1]),
    .flush_e(flushE[1]), .flush_m(flushM[1]), .fwd_a_e(fwdAE[1]), .fwd_b_e(fwdBE[1]),
    .fwd_a_d(fwdAD[1]), .fwd_b_d(fwdBD[1]), .busy(busyO[1]), .stall_cnt(stallCnt1));

  // packing: {busy, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d}
  function automatic logic [14:0] obsVec(input int i);
    return {busyO[i], stallF[i], stallD[i], stallE[i], flushD[i], flushE[i], flushM[i],
            fwdAE[i], fwdBE[i], fwdAD[i], fwdBD[i]};
  endfunction

  function automatic bit wr(input logic en, input logic [3:0] d, input logic [3:0] r);
    return en && (d == r) && (r != 4'd0);
  endfunction

  function automatic logic [1:0] sel(input logic [3:0] r);
    if (wr(reg_wren_m, dst_m, r)) return 2'b01;
    if (wr(reg_wren_w, dst_w, r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit branchWait(input logic [3:0] r);
    bit w;
    w = wr(reg_wren_e, dst_e, r) || (mem_to_reg_m && wr(reg_wren_m, dst_m, r));
`ifndef HAZARD_BRANCH_FWD_EN
    w = w || wr(reg_wren_m, dst_m, r) || wr(reg_wren_w, dst_w, r);
`endif
    return w;
  endfunction

  function automatic logic [14:0] expVec(input bit inBusy);
    logic [1:0] ad, bdv;
    logic [6:0] ctl;
    bit lu, bd;
    ad = 2'b00;
    bdv = 2'b00;
`ifdef HAZARD_BRANCH_FWD_EN
    if (branch_d) begin
      ad  = sel(rs_d);
      bdv = sel(rt_d);
    end
`endif
    lu = mem_to_reg_e && ((uses_rs_d && wr(reg_wren_e, dst_e, rs_d)) ||
                          (uses_rt_d && wr(reg_wren_e, dst_e, rt_d)));
    bd = branch_d && ((uses_rs_d && branchWait(rs_d)) || (uses_rt_d && branchWait(rt_d)));
    if (!rst_n)        ctl = 7'b0000000;
    else if (inBusy)   ctl = 7'b1111001;
    else if (lu || bd) ctl = 7'b0110010;
    else               ctl = {4'b0000, branch_taken_d, 2'b00};
    return {ctl, sel(rs_e), sel(rt_e), ad, bdv};
  endfunction

  task automatic clearIns();
    {rs_d, rt_d, rs_e, rt_e, dst_e, dst_m, dst_w} = '0;
    {uses_rs_d, uses_rt_d, branch_d, branch_taken_d} = '0;
    {reg_wren_e, mem_to_reg_e, multi_e, reg_wren_m, mem_to_reg_m, reg_wren_w} = '0;
  endtask

  // advance one clock and the model with it
  task automatic tick();
    logic [14:0] e0, e1;
    int nLeft, nCnt0, nCnt1;
    bit nDone;
    e0 = expVec(left0 > 0);
    e1 = expVec(1'b0);
    nLeft = left0; nDone = done0; nCnt0 = cnt0; nCnt1 = cnt1;
    if (!rst_n) begin
      nLeft = 0; nDone = 0; nCnt0 = 0; nCnt1 = 0;
    end else begin
      if (e0[12] && cnt0 < 65535) nCnt0 = cnt0 + 1;
      if (e1[12] && cnt1 < 3)     nCnt1 = cnt1 + 1;
      if (left0 > 0) begin
        nLeft = left0 - 1;
        nDone = (nLeft == 0);
      end else begin
        nLeft = (multi_e && !done0) ? LAT0 - 1 : 0;
        nDone = 0;
      end
    end
    @(posedge clk); #1;
    left0 = nLeft; done0 = nDone; cnt0 = nCnt0; cnt1 = nCnt1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearIns();
    mem_to_reg_e = 1; reg_wren_e = 1; dst_e = 2; uses_rt_d = 1; rt_d = 2; branch_taken_d = 1;
    rs_e = 3; dst_m = 3; reg_wren_m = 1;
    @(negedge clk);
    if (obsVec(0) !== expVec(1'b0)) begin
      errors++; $display("FAIL reset_vec: got %b want %b", obsVec(0), expVec(1'b0));
    end
    checks++;
    if (stallD[0] !== 1'b0 || flushD[0] !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: stall_d=%b flush_d=%b want 0 0", stallD[0], flushD[0]);
    end
    checks++;
    if (fwdAE[0] !== 2'b01) begin
      errors++; $display("FAIL reset_fwd: got %b want 01", fwdAE[0]);
    end
    checks++;
    if (stallCnt0 !== 16'd0 || stallCnt1 !== 2'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stallCnt0, stallCnt1);
    end
    checks++;
    tick();
    tick();
    clearIns();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ex_fwd();
    logic [3:0] rsT[3];
    logic [3:0] dmT[3];
    logic [3:0] dwT[3];
    logic [1:0] want[3];
    rsT = '{4'd3, 4'd3, 4'd0};
    dmT = '{4'd3, 4'd5, 4'd0};
    dwT = '{4'd3, 4'd3, 4'd0};
    want = '{2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 3; i++) begin
      clearIns();
      rs_e = rsT[i]; rt_e = rsT[i]; dst_m = dmT[i]; dst_w = dwT[i];
      reg_wren_m = 1; reg_wren_w = 1;
      @(negedge clk);
      if (fwdAE[0] !== want[i] || fwdBE[0] !== want[i]) begin
        errors++; $display("FAIL ex_fwd case%0d: got a=%b b=%b want %b", i, fwdAE[0], fwdBE[0], want[i]);
      end
      checks++;
      if (obsVec(0) !== expVec(left0 > 0)) begin
        errors++; $display("FAIL ex_fwd_vec case%0d: got %b want %b", i, obsVec(0), expVec(left0 > 0));
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_load_use();
    clearIns();
    mem_to_reg_e = 1; reg_wren_e = 1; dst_e = 2; uses_rt_d = 1; rt_d = 2;
    @(negedge clk);
    if (obsVec(0)[14:8] !== 7'b0110010 || stallCnt0 !== 16'd0) begin
      errors++; $display("FAIL load_use: got ctl=%b cnt=%0d want 0110010 cnt=0", obsVec(0)[14:8], stallCnt0);
    end
    checks++;
    tick();
    mem_to_reg_e = 0; reg_wren_e = 0; dst_e = 0;
    dst_m = 2; reg_wren_m = 1; mem_to_reg_m = 1;
    @(negedge clk);
    if (stallD[0] !== 1'b0 || stallCnt0 !== 16'd1) begin
      errors++; $display("FAIL load_use_after: got stall_d=%b cnt=%0d want 0 cnt=1", stallD[0], stallCnt0);
    end
    checks++;
    tick();
    clearIns();
    mem_to_reg_e = 1; reg_wren_e = 1; dst_e = 2; uses_rt_d = 0; rt_d = 2;
    @(negedge clk);
    if (stallD[0] !== 1'b0 || obsVec(0) !== expVec(left0 > 0)) begin
      errors++; $display("FAIL load_unused: got %b want %b", obsVec(0), expVec(left0 > 0));
    end
    checks++;
    tick();
  endtask

  task automatic test_multi();
    int busyCycles;
    logic [3:0] pattern;
    clearIns();
    busyCycles = 0;
    multi_e = 1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) multi_e = 0;
      @(negedge clk);
      if (obsVec(0) !== expVec(left0 > 0)) begin
        errors++; $display("FAIL multi_vec cyc%0d: got %b want %b", c, obsVec(0), expVec(left0 > 0));
      end
      checks++;
      if (busyO[1] !== 1'b0) begin
        errors++; $display("FAIL multi_lat1 cyc%0d: busy=%b want 0", c, busyO[1]);
      end
      checks++;
      if (c < 4) pattern[c] = busyO[0];
      if (busyO[0] === 1'b1 && flushM[0] === 1'b1) busyCycles++;
      tick();
    end
    if (busyCycles != LAT0 - 1 || pattern !== 4'b0110) begin
      errors++; $display("FAIL multi_len: got %0d cycles pattern %b want %0d pattern 0110",
                         busyCycles, pattern, LAT0 - 1);
    end
    checks++;
    multi_e = 1;
    tick();
    @(negedge clk);
    if (busyO[0] !== 1'b1) begin
      errors++; $display("FAIL multi_enter: busy=%b want 1", busyO[0]);
    end
    checks++;
    #1 rst_n = 1'b0;
    left0 = 0; done0 = 0; cnt0 = 0; cnt1 = 0;
    #1;
    if (busyO[0] !== 1'b0 || stallD[0] !== 1'b0 || stallCnt0 !== 16'd0) begin
      errors++; $display("FAIL multi_reset: busy=%b stall_d=%b cnt=%0d want 0 0 0",
                         busyO[0], stallD[0], stallCnt0);
    end
    checks++;
    tick();
    clearIns();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_branch();
    clearIns();
    branch_d = 1; uses_rs_d = 1; rs_d = 4; dst_e = 4; reg_wren_e = 1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin reg_wren_e = 0; dst_e = 0; dst_m = 4; reg_wren_m = 1; end
      if (c == 2) begin reg_wren_m = 0; dst_m = 0; dst_w = 4; reg_wren_w = 1; end
      if (c == 3) begin reg_wren_w = 0; dst_w = 0; end
      @(negedge clk);
      if (obsVec(0) !== expVec(left0 > 0)) begin
        errors++; $display("FAIL branch_vec cyc%0d: got %b want %b", c, obsVec(0), expVec(left0 > 0));
      end
      checks++;
      if (c == 1) begin
`ifdef HAZARD_BRANCH_FWD_EN
        if (stallD[0] !== 1'b0 || fwdAD[0] !== 2'b01) begin
          errors++; $display("FAIL branch_mfwd: stall_d=%b fwd_a_d=%b want 0 01", stallD[0], fwdAD[0]);
        end
`else
        if (stallD[0] !== 1'b1 || fwdAD[0] !== 2'b00) begin
          errors++; $display("FAIL branch_mwait: stall_d=%b fwd_a_d=%b want 1 00", stallD[0], fwdAD[0]);
        end
`endif
        checks++;
      end
      if (c == 0 && stallD[0] !== 1'b1) begin
        errors++; $display("FAIL branch_edep: stall_d=%b want 1", stallD[0]);
      end
      if (c == 0) checks++;
      tick();
    end
    dst_m = 4; reg_wren_m = 1; mem_to_reg_m = 1;
    @(negedge clk);
    if (stallD[0] !== 1'b1 || flushE[0] !== 1'b1) begin
      errors++; $display("FAIL branch_mload: stall_d=%b flush_e=%b want 1 1", stallD[0], flushE[0]);
    end
    checks++;
    tick();
  endtask

  task automatic test_taken_lu();
    clearIns();
    mem_to_reg_e = 1; reg_wren_e = 1; dst_e = 6; uses_rs_d = 1; rs_d = 6; branch_taken_d = 1;
    @(negedge clk);
    if (flushD[0] !== 1'b0 || stallD[0] !== 1'b1) begin
      errors++; $display("FAIL taken_lu_first: flush_d=%b stall_d=%b want 0 1", flushD[0], stallD[0]);
    end
    checks++;
    tick();
    mem_to_reg_e = 0; reg_wren_e = 0; dst_e = 0;
    @(negedge clk);
    if (flushD[0] !== 1'b1 || stallD[0] !== 1'b0) begin
      errors++; $display("FAIL taken_lu_next: flush_d=%b stall_d=%b want 1 0", flushD[0], stallD[0]);
    end
    checks++;
    tick();
  endtask

  task automatic test_saturate();
    clearIns();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_to_reg_e = 1; reg_wren_e = 1; dst_e = 9; uses_rs_d = 1; rs_d = 9;
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk);
    if (stallCnt1 !== 2'd3 || stallCnt1 !== 2'(cnt1)) begin
      errors++; $display("FAIL saturate: got %0d want 3 (model %0d)", stallCnt1, cnt1);
    end
    checks++;
    if (stallCnt0 !== 16'd5) begin
      errors++; $display("FAIL count_wide: got %0d want 5", stallCnt0);
    end
    checks++;
    clearIns();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rs_d = 4'($urandom_range(0, 3)); rt_d = 4'($urandom_range(0, 3));
      rs_e = 4'($urandom_range(0, 3)); rt_e = 4'($urandom_range(0, 3));
      dst_e = 4'($urandom_range(0, 3)); dst_m = 4'($urandom_range(0, 3)); dst_w = 4'($urandom_range(0, 3));
      uses_rs_d = 1'($urandom); uses_rt_d = 1'($urandom);
      branch_d = 1'($urandom); branch_taken_d = 1'($urandom);
      reg_wren_e = 1'($urandom); mem_to_reg_e = 1'($urandom);
      reg_wren_m = 1'($urandom); mem_to_reg_m = 1'($urandom); reg_wren_w = 1'($urandom);
      multi_e = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (obsVec(0) !== expVec(left0 > 0)) begin
        errors++; $display("FAIL rand_vec0 cyc%0d: got %b want %b", c, obsVec(0), expVec(left0 > 0));
      end
      checks++;
      if (obsVec(1) !== expVec(1'b0)) begin
        errors++; $display("FAIL rand_vec1 cyc%0d: got %b want %b", c, obsVec(1), expVec(1'b0));
      end
      checks++;
      if (stallCnt0 !== 16'(cnt0) || stallCnt1 !== 2'(cnt1)) begin
        errors++; $display("FAIL rand_cnt cyc%0d: got %0d/%0d want %0d/%0d", c, stallCnt0, stallCnt1, cnt0, cnt1);
      end
      checks++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_load_use();
    test_multi();
    test_branch();
    test_taken_lu();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard, forwarding and stall controller for the 5-stage pipeline; the successor to the fixed 4-bit-register hazard unit. Resolves EX-stage operand forwarding with correct youngest-first priority, decode-stage branch operand forwarding, load-use and branch-dependency stalls, and multi-cycle execute occupancy via a registered FSM. Drives the F/D/E pipeline-register enables and bubbles, and exposes a saturating stall-cycle counter for performance monitoring.

## Interface
- REG_BITS, 4, register-index width; register 0 is hardwired zero and is never a forwarding or stall source.
- MUL_LAT, 3, total EX-stage cycles for a multi-cycle op (≥1).
- CNT_BITS, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- rs_d, rt_d  in  REG_BITS  decode source registers
- uses_rs_d, uses_rt_d  in  1  decode instruction actually reads rs/rt
- branch_d  in  1  decode holds a branch that compares registers
- branch_taken_d  in  1  decode branch resolves taken
- rs_e, rt_e, dst_e  in  REG_BITS  EX sources and destination
- reg_wren_e, mem_to_reg_e, multi_e  in  1  EX writes a register, is a load, is a multi-cycle op
- dst_m, dst_w  in  REG_BITS  MEM and WB destinations
- reg_wren_m, mem_to_reg_m, reg_wren_w  in  1  MEM/WB write enables; MEM is a load
- stall_f, stall_d, stall_e  out  1  hold PC, IF/ID, ID/EX registers
- flush_d  out  1  squash IF/ID (taken branch)
- flush_e  out  1  insert bubble into ID/EX
- flush_m  out  1  insert bubble into EX/MEM
- fwd_a_e, fwd_b_e  out  2  ALU operand select: 00 regfile, 01 from MEM, 10 from WB
- fwd_a_d, fwd_b_d  out  2  branch comparator select: 00 regfile, 01 from MEM, 10 from WB
- busy  out  1  multi-cycle op occupying EX
- stall_cnt  out  CNT_BITS  saturating count of cycles with stall_d=1

## Operation
- Writer match W(x,r) = reg_wren_x & dst_x==r & r!=0.
- EX forwarding: fwd_a_e = W(m,rs_e) ? 01 : W(w,rs_e) ? 10 : 00; same for rt_e/fwd_b_e. MEM wins over WB.
- Load-use: lu = mem_to_reg_e & (uses_rs_d & W(e,rs_d) | uses_rt_d & W(e,rt_d)).
- Branch dependency: bd = branch_d & (any used source matches W(e,·), or matches W(m,·) with mem_to_reg_m).
- Decode forwarding: for branch_d, fwd_*_d = W(m,r) ? 01 : W(w,r) ? 10 : 00; 00 when branch_d=0.
- FSM states RUN, MBUSY; 2-bit-wide-enough down-counter mcnt; one-cycle mask flag mdone.
  - RUN: if multi_e & ~mdone & MUL_LAT>1 → MBUSY, mcnt=MUL_LAT-2. mdone cleared every RUN cycle.
  - MBUSY: if mcnt==0 → RUN, mdone=1; else mcnt-1.
- Outputs, priority high to low:
  - MBUSY: busy=stall_f=stall_d=stall_e=flush_m=1; flush_d=flush_e=0.
  - RUN & (lu|bd): stall_f=stall_d=flush_e=1; flush_d=0.
  - RUN otherwise: flush_d=branch_taken_d; all stalls 0.
- stall_cnt increments when stall_d=1, holds at all-ones.

## Timing
- All outputs except stall_cnt are combinational from inputs and registered state; no input-to-state path except multi_e, mdone.
- Multi-cycle op: exactly MUL_LAT-1 stall cycles; the op leaves EX on the cycle after MBUSY exits (mdone prevents re-entry that cycle). MUL_LAT=1: never MBUSY.
- Load-use and E-dependent branch: one stall cycle; M-load-dependent branch: one stall cycle; back-to-back load then branch on it: two.
- Simultaneous lu and branch_taken_d: stall wins, flush_d=0 until stall clears.
- Reset (any time, incl. mid-MBUSY): state RUN, mcnt=0, mdone=0, stall_cnt=0; all outputs 0 while rst_n=0 other than combinational fwd_* which follow inputs.

## Configuration
- HAZARD_BRANCH_FWD_EN defined: decode forwarding as above.
- Undefined: fwd_a_d=fwd_b_d=00 constant; bd additionally includes any used source matching W(m,·) or W(w,·), so the branch stalls until the value is in the register file.

## Test plan
- rs_e=3, dst_m=3, dst_w=3, both wren → fwd_a_e=01; dst_m=5 → fwd_a_e=10; rs_e=0 with dst_m=0 → 00.
- Load r2 in EX, decode uses rt_d=2 → one cycle stall_f=stall_d=flush_e=1, stall_cnt 0→1; unused rt_d → no stall.
- MUL_LAT=3, multi_e=1 for 3 cycles → busy high exactly 2 cycles, flush_m=1 those cycles, then RUN with no re-entry; reset asserted mid-MBUSY → busy=0 immediately.
- Branch on r4, dst_e=4 wren → stall 1 cycle; next cycle dst_m=4 non-load → fwd_a_d=01 (macro on) or stall continues (macro off).
- branch_taken_d=1 with lu=1 → flush_d=0 first cycle, flush_d=1 the following cycle.
- CNT_BITS=2, hold stall 5 cycles → stall_cnt saturates at 3.
